control_sequencer: RTL and testbench

//  Parametrised multi-cycle control sequencer for the CPU datapath; next generation of the instruction control unit.

---
 rtl/ctrl_pkg.sv | 108 ++++++++++
 rtl/ctrl_cw_table.sv | 92 +++++++++
 rtl/control_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_control_sequencer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared types, encodings and decode helpers for the control sequencer and its control word table.
package ctrl_pkg;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_TRAP  = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        IC_DP_REG = 3'd0,
        IC_DP_IMM = 3'd1,
        IC_BRANCH = 3'd2,
        IC_LDST   = 3'd3,
        IC_UNDEF  = 3'd4
    } iclass_e;

    localparam logic [3:0] STEPS_DP_REG = 4'd1;
    localparam logic [3:0] STEPS_DP_IMM = 4'd1;
    localparam logic [3:0] STEPS_BRANCH = 4'd2;
    localparam logic [3:0] STEPS_LDST   = 4'd3;

    localparam logic [1:0] CAUSE_NONE  = 2'b00;
    localparam logic [1:0] CAUSE_UNDEF = 2'b01;
    localparam logic [1:0] CAUSE_BUS   = 2'b10;

    localparam logic [2:0] K_IMM12  = 3'd0;
    localparam logic [2:0] K_OFF9   = 3'd1;
    localparam logic [2:0] K_BR26   = 3'd2;
    localparam logic [2:0] K_BR19   = 3'd3;
    localparam logic [2:0] K_MOV16  = 3'd4;
    localparam logic [2:0] K_ONES16 = 3'd5;
    localparam logic [2:0] K_SHAMT  = 3'd6;
    localparam logic [2:0] K_ZERO   = 3'd7;

    localparam logic [4:0] FS_ADD    = 5'd2;
    localparam logic [1:0] PC_HOLD   = 2'b00;
    localparam logic [1:0] PC_INC    = 2'b01;
    localparam logic [1:0] PC_BRANCH = 2'b10;
    localparam logic [1:0] MD_ALU    = 2'b00;
    localparam logic [1:0] MD_MEM    = 2'b01;
    localparam logic [1:0] MD_PC     = 2'b10;

    localparam int CW_BASE_W = 37;

    // Field layout of the 37-bit control word, MSB first.
    typedef struct packed {
        logic [4:0] da;
        logic [4:0] aa;
        logic [4:0] ba;
        logic       b_sel;
        logic [4:0] fs;
        logic       reg_write;
        logic       mem_write;
        logic       mem_read;
        logic [1:0] md_sel;
        logic [1:0] pc_sel;
        logic       ir_load;
        logic       status_load;
        logic [6:0] rsvd;
    } cw_t;

    // Fetch: mem_read, pc_sel=PC_INC, ir_load.
    localparam logic [CW_BASE_W-1:0] CW_FETCH = 37'h2300;

    function automatic iclass_e decode_class(input logic [3:0] op);
        // op = IR[28:25]
        if (op[2] & op[0] & ~op[1]) begin
            return IC_DP_REG;
        end else if (op[3] & ~op[2] & op[1]) begin
            return IC_BRANCH;
        end else if (op[3] & ~op[2] & ~op[1]) begin
            return IC_DP_IMM;
        end else if (op[2] & ~op[0]) begin
            return IC_LDST;
        end else begin
            return IC_UNDEF;
        end
    endfunction

    function automatic logic [3:0] class_steps(input iclass_e c);
        case (c)
            IC_DP_REG: return STEPS_DP_REG;
            IC_DP_IMM: return STEPS_DP_IMM;
            IC_BRANCH: return STEPS_BRANCH;
            IC_LDST:   return STEPS_LDST;
            default:   return 4'd0;
        endcase
    endfunction

    // cond[3:1] picks the base test over {N,Z,C,V}; cond[0] inverts it.
    function automatic logic cond_met(input logic [3:0] cond, input logic [3:0] st);
        logic n, z, c, v, base;
        {n, z, c, v} = st;
        case (cond[3:1])
            3'd0:    base = z;
            3'd1:    base = c;
            3'd2:    base = n;
            3'd3:    base = v;
            3'd4:    base = c & ~z;
            3'd5:    base = ~(n ^ v);
            3'd6:    base = ~z & ~(n ^ v);
            default: base = 1'b1;
        endcase
        return base ^ cond[0];
    endfunction

endpackage

// File: rtl/ctrl_cw_table.sv
// Combinational control word table: (iclass, step, status, IR) -> {control word, k_sel}.
module ctrl_cw_table
    import ctrl_pkg::*;
#(
    parameter int CW_WIDTH = 37,
    parameter int STEP_W   = 2
) (
    input  iclass_e             iclass,
    input  logic [STEP_W-1:0]   step,
    input  logic [3:0]          status,
    input  logic [31:0]         ir,
    output logic [CW_WIDTH-1:0] control_word,
    output logic [2:0]          k_sel
);

    cw_t        cw_s;
    logic [2:0] ksel_s;
    logic       taken_s;
    logic       unused_ir_s;

    assign unused_ir_s = ^{ir[28:24], ir[15:10]};

    // Per-class, per-step control word and constant selection.
    always_comb begin
        cw_s    = '0;
        ksel_s  = K_ZERO;
        taken_s = cond_met(ir[3:0], status);
        case (iclass)
            IC_DP_REG: begin
                cw_s.da          = ir[4:0];
                cw_s.aa          = ir[9:5];
                cw_s.ba          = ir[20:16];
                cw_s.fs          = {1'b0, ir[30:29], ir[22:21]};
                cw_s.reg_write   = 1'b1;
                cw_s.status_load = ir[29];
            end
            IC_DP_IMM: begin
                cw_s.da          = ir[4:0];
                cw_s.aa          = ir[9:5];
                cw_s.b_sel       = 1'b1;
                cw_s.fs          = {1'b0, ir[30:29], 2'b00};
                cw_s.reg_write   = 1'b1;
                cw_s.status_load = ir[29];
                case (ir[23:22])
                    2'b00:   ksel_s = K_IMM12;
                    2'b01:   ksel_s = K_SHAMT;
                    2'b10:   ksel_s = K_MOV16;
                    default: ksel_s = K_ONES16;
                endcase
            end
            IC_BRANCH: begin
                ksel_s     = ir[29] ? K_BR19 : K_BR26;
                cw_s.b_sel = 1'b1;
                cw_s.fs    = FS_ADD;
                // Step 1 commits the target; a failed condition leaves the PC alone.
                if (step == STEP_W'(0)) begin
                    cw_s.pc_sel = PC_HOLD;
                end else begin
                    cw_s.pc_sel    = (ir[29] & ~taken_s) ? PC_HOLD : PC_BRANCH;
                    cw_s.reg_write = ir[31] & ~ir[29];
                    cw_s.da        = 5'd30;
                    cw_s.md_sel    = MD_PC;
                end
            end
            IC_LDST: begin
                ksel_s     = K_OFF9;
                cw_s.aa    = ir[9:5];
                cw_s.b_sel = 1'b1;
                cw_s.fs    = FS_ADD;
                if (step == STEP_W'(1)) begin
                    cw_s.mem_read  = ir[22];
                    cw_s.mem_write = ~ir[22];
                    cw_s.ba        = ir[4:0];
                end else if (step == STEP_W'(2)) begin
                    cw_s.da        = ir[4:0];
                    cw_s.reg_write = ir[22];
                    cw_s.md_sel    = MD_MEM;
                end else begin
                    cw_s.md_sel = MD_ALU;
                end
            end
            default: begin
                cw_s   = '0;
                ksel_s = K_ZERO;
            end
        endcase
    end

    assign control_word = CW_WIDTH'(cw_s);
    assign k_sel        = ksel_s;

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle control sequencer: FSM, micro-step counter, memory watchdog and constant generator.
// Optional retired-instruction counter enabled by defining CTRL_RETIRE_CNT_EN.
module control_sequencer
    import ctrl_pkg::*;
#(
    parameter int CW_WIDTH   = 37,
    parameter int K_WIDTH    = 32,
    parameter int STEP_W     = 2,
    parameter int WAIT_LIMIT = 15
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [31:0]         IR,
    input  logic [3:0]          status,
    input  logic                mem_ready,
    input  logic                trap_ack,
    output logic                mem_req,
    output logic [CW_WIDTH-1:0] controlWord,
    output logic [K_WIDTH-1:0]  k,
    output logic                instr_done,
    output logic                trap,
    output logic [1:0]          trap_cause
`ifdef CTRL_RETIRE_CNT_EN
    ,
    output logic [31:0]         retired
`endif
);

    localparam int WCNT_W = $clog2(WAIT_LIMIT + 1);
    localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(WAIT_LIMIT - 1);

    state_e              state_r, state_s;
    logic [STEP_W-1:0]   step_r, step_s;
    logic [WCNT_W-1:0]   wait_cnt_r, wait_cnt_s;
    logic [1:0]          cause_r, cause_s;
    iclass_e             iclass_s;
    logic [CW_WIDTH-1:0] table_cw_s, cw_s;
    logic [2:0]          table_ksel_s, ksel_s;
    logic                mem_req_s, done_s, last_step_s;

    assign iclass_s    = decode_class(IR[28:25]);
    assign last_step_s = (int'(step_r) == int'(class_steps(iclass_s)) - 1);

    ctrl_cw_table #(
        .CW_WIDTH (CW_WIDTH),
        .STEP_W   (STEP_W)
    ) u_cw_table (
        .iclass       (iclass_s),
        .step         (step_r),
        .status       (status),
        .ir           (IR),
        .control_word (table_cw_s),
        .k_sel        (table_ksel_s)
    );

    // Next state, step, watchdog and cause; per-state output decode.
    always_comb begin
        state_s    = state_r;
        step_s     = step_r;
        wait_cnt_s = wait_cnt_r;
        cause_s    = cause_r;
        mem_req_s  = 1'b0;
        done_s     = 1'b0;
        cw_s       = '0;
        ksel_s     = K_ZERO;
        case (state_r)
            ST_FETCH: begin
                mem_req_s = 1'b1;
                cw_s      = CW_WIDTH'(CW_FETCH);
                if (mem_ready) begin
                    state_s    = ST_EXEC;
                    step_s     = '0;
                    wait_cnt_s = '0;
                end else if (wait_cnt_r == WAIT_LAST) begin
                    state_s    = ST_TRAP;
                    cause_s    = CAUSE_BUS;
                    wait_cnt_s = '0;
                end else begin
                    wait_cnt_s = wait_cnt_r + WCNT_W'(1);
                end
            end
            ST_EXEC: begin
                if (iclass_s == IC_UNDEF) begin
                    state_s = ST_TRAP;
                    cause_s = CAUSE_UNDEF;
                    step_s  = '0;
                end else begin
                    cw_s   = table_cw_s;
                    ksel_s = table_ksel_s;
                    // Load/store data phase stalls on the handshake under the same watchdog.
                    if ((iclass_s == IC_LDST) && (step_r == STEP_W'(1))) begin
                        mem_req_s = 1'b1;
                        if (mem_ready) begin
                            step_s     = step_r + STEP_W'(1);
                            wait_cnt_s = '0;
                        end else if (wait_cnt_r == WAIT_LAST) begin
                            state_s    = ST_TRAP;
                            cause_s    = CAUSE_BUS;
                            step_s     = '0;
                            wait_cnt_s = '0;
                        end else begin
                            wait_cnt_s = wait_cnt_r + WCNT_W'(1);
                        end
                    end else if (last_step_s) begin
                        done_s  = 1'b1;
                        state_s = ST_FETCH;
                        step_s  = '0;
                    end else begin
                        step_s = step_r + STEP_W'(1);
                    end
                end
            end
            ST_TRAP: begin
                if (trap_ack) begin
                    state_s = ST_FETCH;
                    cause_s = CAUSE_NONE;
                end else begin
                    state_s = ST_TRAP;
                end
            end
            default: begin
                state_s    = ST_FETCH;
                step_s     = '0;
                wait_cnt_s = '0;
                cause_s    = CAUSE_NONE;
            end
        endcase
    end

    // Sequencer state registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r    <= ST_FETCH;
            step_r     <= '0;
            wait_cnt_r <= '0;
            cause_r    <= CAUSE_NONE;
        end else begin
            state_r    <= state_s;
            step_r     <= step_s;
            wait_cnt_r <= wait_cnt_s;
            cause_r    <= cause_s;
        end
    end

    // Constant generator.
    always_comb begin
        case (ksel_s)
            K_IMM12:  k = K_WIDTH'($signed(IR[21:10]));
            K_OFF9:   k = K_WIDTH'($signed(IR[20:12]));
            K_BR26:   k = K_WIDTH'($signed(IR[25:0]));
            K_BR19:   k = K_WIDTH'($signed(IR[23:5]));
            K_MOV16:  k = K_WIDTH'($signed(IR[20:5]));
            K_ONES16: k = K_WIDTH'(16'hFFFF);
            K_SHAMT:  k = K_WIDTH'(IR[15:10]);
            default:  k = '0;
        endcase
    end

    // FETCH decodes to an active request, so hold the request side quiet while reset is asserted.
    always_comb begin
        if (!reset) begin
            mem_req     = 1'b0;
            controlWord = '0;
        end else begin
            mem_req     = mem_req_s;
            controlWord = cw_s;
        end
    end

    assign instr_done = done_s;
    assign trap       = (state_r == ST_TRAP);
    assign trap_cause = cause_r;

`ifdef CTRL_RETIRE_CNT_EN
    // Retired-instruction counter, wraps naturally.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            retired <= 32'd0;
        end else if (done_s) begin
            retired <= retired + 32'd1;
        end else begin
            retired <= retired;
        end
    end
`endif

endmodule

// File: tb/tb_control_sequencer.sv
// Directed self-checking bench for control_sequencer at K_WIDTH=32 and K_WIDTH=64.
module tb_control_sequencer;

    logic        clock;
    logic        reset;
    logic [31:0] ir_s;
    logic [3:0]  status_s;
    logic        mem_ready_s;
    logic        trap_ack_s;

    logic        mem_req_s,  mem_req64_s;
    logic [36:0] cw_s,       cw64_s;
    logic [31:0] k_s;
    logic [63:0] k64_s;
    logic        done_s,     done64_s;
    logic        trap_s,     trap64_s;
    logic [1:0]  cause_s,    cause64_s;
`ifdef CTRL_RETIRE_CNT_EN
    logic [31:0] retired_s,  retired64_s;
`endif

    int checks_cnt = 0;
    int fail_cnt   = 0;
    int lat_cnt;
    int req_cnt;

    control_sequencer #(.CW_WIDTH(37), .K_WIDTH(32), .STEP_W(2), .WAIT_LIMIT(15)) dut (
        .clock       (clock),
        .reset       (reset),
        .IR          (ir_s),
        .status      (status_s),
        .mem_ready   (mem_ready_s),
        .trap_ack    (trap_ack_s),
        .mem_req     (mem_req_s),
        .controlWord (cw_s),
        .k           (k_s),
        .instr_done  (done_s),
        .trap        (trap_s),
        .trap_cause  (cause_s)
`ifdef CTRL_RETIRE_CNT_EN
        ,
        .retired     (retired_s)
`endif
    );

    control_sequencer #(.CW_WIDTH(37), .K_WIDTH(64), .STEP_W(2), .WAIT_LIMIT(15)) dut64 (
        .clock       (clock),
        .reset       (reset),
        .IR          (ir_s),
        .status      (status_s),
        .mem_ready   (mem_ready_s),
        .trap_ack    (trap_ack_s),
        .mem_req     (mem_req64_s),
        .controlWord (cw64_s),
        .k           (k64_s),
        .instr_done  (done64_s),
        .trap        (trap64_s),
        .trap_cause  (cause64_s)
`ifdef CTRL_RETIRE_CNT_EN
        ,
        .retired     (retired64_s)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #2;
    endtask

    // Run one instruction from FETCH with an always-ready memory; returns in the next FETCH.
    task automatic do_instr(input logic [31:0] ir);
        int n;
        ir_s        = ir;
        mem_ready_s = 1'b1;
        n           = 0;
        #1;
        while (!done_s && n < 8) begin
            cyc();
            #1;
            n++;
        end
        if (n >= 8) begin
            check_val("do_instr_timeout", 64'd0, 64'd1);
        end
        cyc();
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset       = 1'b0;
        ir_s        = 32'h0A00_0000;
        status_s    = 4'h0;
        mem_ready_s = 1'b1;
        trap_ack_s  = 1'b0;
        repeat (2) cyc();
        #1;
        check_val("rst_mem_req", mem_req_s, 64'd0);
        check_val("rst_cw", cw_s, 64'd0);
        check_val("rst_trap", trap_s, 64'd0);
        check_val("rst_cause", cause_s, 64'd0);
        check_val("rst_done", done_s, 64'd0);
        check_val("rst_k", k_s, 64'd0);

        // DP_REG: one fetch cycle, one exec cycle.
        reset = 1'b1;
        #1;
        check_val("t1_fetch_req", mem_req_s, 64'd1);
        check_val("t1_fetch_cw", cw_s, 64'h2300);
        cyc(); #1;
        check_val("t1_exec_done", done_s, 64'd1);
        check_val("t1_exec_req", mem_req_s, 64'd0);
        cyc(); #1;
        check_val("t1_refetch_req", mem_req_s, 64'd1);
        check_val("t1_refetch_done", done_s, 64'd0);

        // LDST load with off9 = 9'h1FF and 3 wait cycles in step 1.
        ir_s = 32'h085F_F000;
        lat_cnt = 1;
        req_cnt = 0;
        cyc(); mem_ready_s = 1'b0; #1; lat_cnt++;
        check_val("t2_step0_req", mem_req_s, 64'd0);
        check_val("t2_k32", k_s, 64'hFFFF_FFFF);
        check_val("t2_k64", k64_s, 64'hFFFF_FFFF_FFFF_FFFF);
        repeat (3) begin
            cyc(); #1; lat_cnt++;
            req_cnt += int'(mem_req_s);
        end
        cyc(); mem_ready_s = 1'b1; #1; lat_cnt++;
        req_cnt += int'(mem_req_s);
        cyc(); #1; lat_cnt++;
        check_val("t2_done", done_s, 64'd1);
        check_val("t2_step2_req", mem_req_s, 64'd0);
        check_val("t2_req_cycles", 64'(req_cnt), 64'd4);
        check_val("t2_latency", 64'(lat_cnt), 64'd7);

        // Fetch timeout: 15 wait cycles then TRAP with cause 10.
        cyc(); mem_ready_s = 1'b0; #1;
        repeat (14) cyc();
        #1;
        check_val("t3_still_fetch", mem_req_s, 64'd1);
        check_val("t3_no_trap_yet", trap_s, 64'd0);
        cyc(); mem_ready_s = 1'b1; #1;
        check_val("t3_trap", trap_s, 64'd1);
        check_val("t3_cause", cause_s, 64'd2);
        check_val("t3_trap_cw", cw_s, 64'd0);
        check_val("t3_trap_req", mem_req_s, 64'd0);
        cyc(); #1;
        check_val("t3_trap_held", trap_s, 64'd1);
        check_val("t3_cause_held", cause_s, 64'd2);
        trap_ack_s = 1'b1;
        cyc(); trap_ack_s = 1'b0; #1;
        check_val("t3_ack_trap", trap_s, 64'd0);
        check_val("t3_ack_cause", cause_s, 64'd0);
        check_val("t3_ack_fetch", mem_req_s, 64'd1);

        // Undefined instruction, then reset in the middle of TRAP.
        ir_s = 32'h0000_0000;
        cyc(); #1;
        check_val("t4_undef_cw", cw_s, 64'd0);
        check_val("t4_undef_done", done_s, 64'd0);
        cyc(); #1;
        check_val("t4_trap", trap_s, 64'd1);
        check_val("t4_cause", cause_s, 64'd1);
        reset = 1'b0;
        #1;
        check_val("t4_rst_trap", trap_s, 64'd0);
        check_val("t4_rst_cause", cause_s, 64'd0);
        check_val("t4_rst_req", mem_req_s, 64'd0);
        check_val("t4_rst_cw", cw_s, 64'd0);
        cyc(); reset = 1'b1; #1;
        check_val("t4_post_rst_fetch", mem_req_s, 64'd1);

        // DP_IMM constants: sext IR[21:10] and zext IR[15:10].
        ir_s = 32'h1020_0000;
        cyc(); #1;
        check_val("t5_imm12_done", done_s, 64'd1);
        check_val("t5_imm12_k32", k_s, 64'hFFFF_F800);
        check_val("t5_imm12_k64", k64_s, 64'hFFFF_FFFF_FFFF_F800);
        cyc(); ir_s = 32'h1040_FC00; #1;
        cyc(); #1;
        check_val("t5_shamt_k32", k_s, 64'd63);
        check_val("t5_shamt_k64", k64_s, 64'd63);

        // Unconditional branch: two steps; trap_ack outside TRAP has no effect.
        cyc(); ir_s = 32'h1600_0000; trap_ack_s = 1'b1; #1;
        cyc(); #1;
        check_val("t5_br_step0_done", done_s, 64'd0);
        check_val("t5_br_k32", k_s, 64'hFE00_0000);
        check_val("t5_br_k64", k64_s, 64'hFFFF_FFFF_FE00_0000);
        cyc(); #1;
        check_val("t5_br_step1_done", done_s, 64'd1);
        check_val("t5_br_trap", trap_s, 64'd0);
        trap_ack_s = 1'b0;
        cyc(); #1;
        check_val("t5_br_refetch", mem_req_s, 64'd1);

`ifdef CTRL_RETIRE_CNT_EN
        reset = 1'b0;
        cyc();
        reset = 1'b1;
        #1;
        check_val("t6_retired_rst", retired_s, 64'd0);
        for (int i = 0; i < 5; i++) begin
            do_instr(32'h1000_0000);
        end
        check_val("t6_retired_5", retired_s, 64'd5);
        force dut.retired = 32'hFFFF_FFFF;
        #1;
        release dut.retired;
        do_instr(32'h1000_0000);
        check_val("t6_retired_wrap", retired_s, 64'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
        $finish;
    end

endmodule
